// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch slice.
//   - Digit select codes used on sel / wr_sel buses.
//   - Per-digit maxima used for range checking of manual digit writes.
//   - Encoding of the adjust-mode controller state.
//   - num_in_range(): true when a value is legal for the selected digit.
package stopwatch_pkg;

  localparam logic [1:0] DIG_SEC_R = 2'd0;
  localparam logic [1:0] DIG_SEC_L = 2'd1;
  localparam logic [1:0] DIG_MIN_R = 2'd2;
  localparam logic [1:0] DIG_MIN_L = 2'd3;

  localparam logic [3:0] MAX_SEC_L = 4'd5;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // Kept as plain constants so legacy code comparing raw codes still works.
  typedef logic [1:0] adj_state_t;
  localparam adj_state_t ST_IDLE = 2'd0;
  localparam adj_state_t ST_EDIT = 2'd1;
  localparam adj_state_t ST_REQ  = 2'd2;

  // Only the tens-of-seconds digit is limited to 0-5; every other digit is 0-9.
  function automatic logic num_in_range(input logic [1:0] dig, input logic [3:0] value);
    logic [3:0] limit;
    limit = (dig == DIG_SEC_L) ? MAX_SEC_L : MAX_DIGIT;
    return (value <= limit);
  endfunction

endpackage

// File: rtl/stopwatch_adjust_blink.sv
// Blink generator for adjust mode.
// Counts tick_adj strobes while active; every BLINK_DIV strobes the phase
// toggles. While the phase is high the digit picked by sel is requested
// blank via a one-hot mask (bit index = sel code).
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   active     controller is out of IDLE; low clears counter, phase and mask
//   tick_adj   one-cycle 5 Hz strobe
//   sel        live digit select
//   blink_mask registered one-hot blank request
module stopwatch_adjust_blink
  import stopwatch_pkg::*;
#(
  parameter int BLINK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic       tick_adj,
  input  logic [1:0] sel,
  output logic [3:0] blink_mask
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic          phase_reg;
  logic          phase_next;
  logic          wrap;
  logic [3:0]    mask_next;

  always_comb begin
    wrap       = tick_adj && (cnt_reg == CNT_LAST);
    phase_next = phase_reg ^ wrap;
  end

  // Mask follows the phase that is being stored this edge, so the display
  // sees the new phase in the same cycle the phase register changes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign mask_next[gi] = phase_next && (sel == 2'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      // Held clear outside adjust mode so entry always starts digit-visible.
      cnt_reg    <= '0;
      phase_reg  <= 1'b0;
      blink_mask <= 4'b0000;
    end else begin
      if (tick_adj) begin
        cnt_reg <= wrap ? '0 : cnt_reg + CW'(1);
      end
      phase_reg  <= phase_next;
      blink_mask <= mask_next;
    end
  end

endmodule

// File: rtl/stopwatch_adjust.sv
// Adjust-mode controller for the stopwatch.
// Converts switch settings plus the debounced set button into single digit
// write requests (valid/ready) toward the time counter, rejects values that
// are out of range for the chosen digit, and drives the adjust blink mask.
// Build option: define STOPWATCH_ADJ_BLINK_EN to include the blink
// generator; otherwise blink_mask is constant zero.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   tick_adj     5 Hz strobe used for blink timing
//   adj_sw       adjust-mode switch level
//   sel, num     digit select and value to write
//   btn_set      debounced set button (level; rising edge commits)
//   wr_valid/wr_ready/wr_sel/wr_val  write request to the counter
//   rej          one-cycle pulse when a commit value is out of range
//   adj_active   high while the controller is not IDLE
//   blink_mask   one-hot digit blank request for the display
module stopwatch_adjust
  import stopwatch_pkg::*;
#(
  parameter int BLINK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_adj,
  input  logic       adj_sw,
  input  logic [1:0] sel,
  input  logic [3:0] num,
  input  logic       btn_set,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [1:0] wr_sel,
  output logic [3:0] wr_val,
  output logic       rej,
  output logic       adj_active,
  output logic [3:0] blink_mask
);

  adj_state_t state_reg;
  adj_state_t state_next;
  logic       btn_q_reg;
  logic       commit;
  logic       num_ok;

  // Holding the button gives one event only: act on the rising edge.
  assign commit = btn_set && !btn_q_reg;
  assign num_ok = num_in_range(sel, num);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (adj_sw) state_next = ST_EDIT;
      end
      ST_EDIT: begin
        // Leaving adjust mode wins over a simultaneous commit.
        if (!adj_sw)             state_next = ST_IDLE;
        else if (commit && num_ok) state_next = ST_REQ;
      end
      ST_REQ: begin
        // A started write always completes, even if adj_sw has dropped.
        if (wr_valid && wr_ready) state_next = adj_sw ? ST_EDIT : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      btn_q_reg  <= 1'b0;
      wr_valid   <= 1'b0;
      wr_sel     <= 2'd0;
      wr_val     <= 4'd0;
      rej        <= 1'b0;
      adj_active <= 1'b0;
    end else begin
      state_reg  <= state_next;
      btn_q_reg  <= btn_set;
      adj_active <= (state_next != ST_IDLE);
      rej        <= (state_reg == ST_EDIT) && adj_sw && commit && !num_ok;
      if ((state_reg == ST_EDIT) && (state_next == ST_REQ)) begin
        // Payload is captured once; sel/num changes during REQ are ignored.
        wr_valid <= 1'b1;
        wr_sel   <= sel;
        wr_val   <= num;
      end else if ((state_reg == ST_REQ) && wr_valid && wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end

`ifdef STOPWATCH_ADJ_BLINK_EN
  stopwatch_adjust_blink #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (state_reg != ST_IDLE),
    .tick_adj   (tick_adj),
    .sel        (sel),
    .blink_mask (blink_mask)
  );
`else
  // Blink disabled: tick input and divider parameter have no function here.
  logic unused_blink;
  assign unused_blink = tick_adj ^ (BLINK_DIV == 0);
  assign blink_mask   = 4'b0000;
`endif

endmodule

// File: tb/tb_stopwatch_adjust.sv
module tb_stopwatch_adjust;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_adj;
  logic       adj_sw;
  logic [1:0] sel;
  logic [3:0] num;
  logic       btn_set;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_sel;
  logic [3:0] wr_val;
  logic       rej;
  logic       adj_active;
  logic [3:0] blink_mask;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: largest legal value per digit (sec_r, sec_l, min_r, min_l).
  int max_tab [4] = '{9, 5, 9, 9};
  int last_sel = 0;
  int last_val = 0;

  always #5 clk = ~clk;

  stopwatch_adjust #(.BLINK_DIV(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_adj   (tick_adj),
    .adj_sw     (adj_sw),
    .sel        (sel),
    .num        (num),
    .btn_set    (btn_set),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_sel     (wr_sel),
    .wr_val     (wr_val),
    .rej        (rej),
    .adj_active (adj_active),
    .blink_mask (blink_mask)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One commit transaction: button edge, then (if accepted) 'hold' cycles of
  // wr_ready low before the handshake. 'early' raises wr_ready up front.
  task automatic do_commit(input int s, input int n, input int hold, input bit early);
    bit ok;
    ok       = (n <= max_tab[s]);
    sel      = 2'(s);
    num      = 4'(n);
    wr_ready = early;
    btn_set  = 1'b1;
    step();
    btn_set = 1'b0;
    $display("commit sel=%0d num=%0d hold=%0d early=%0d accept=%0d", s, n, hold, early, ok);
    if (ok) begin
      last_sel = s;
      last_val = n;
      chk("valid_rise", int'(wr_valid), 1);
      chk("rej_low", int'(rej), 0);
      chk("wr_sel", int'(wr_sel), s);
      chk("wr_val", int'(wr_val), n);
      if (!early) begin
        for (int i = 0; i < hold; i++) begin
          sel = 2'($urandom_range(0, 3));
          num = 4'($urandom_range(0, 15));
          step();
          chk("valid_hold", int'(wr_valid), 1);
          chk("sel_hold", int'(wr_sel), s);
          chk("val_hold", int'(wr_val), n);
        end
        wr_ready = 1'b1;
      end
      step();
      wr_ready = 1'b0;
      chk("valid_drop", int'(wr_valid), 0);
      chk("active_after", int'(adj_active), int'(adj_sw));
    end else begin
      chk("rej_pulse", int'(rej), 1);
      chk("no_valid", int'(wr_valid), 0);
      chk("sel_kept", int'(wr_sel), last_sel);
      chk("val_kept", int'(wr_val), last_val);
      step();
      chk("rej_one_cycle", int'(rej), 0);
      chk("stay_edit", int'(adj_active), 1);
    end
  endtask

  initial begin
    int valid_cycles;
    int exp_mask;

    rst_n = 1'b0; tick_adj = 1'b0; adj_sw = 1'b0; sel = 2'd0; num = 4'd0;
    btn_set = 1'b0; wr_ready = 1'b0;
    step(); step();
    chk("rst_valid", int'(wr_valid), 0);
    chk("rst_sel", int'(wr_sel), 0);
    chk("rst_val", int'(wr_val), 0);
    chk("rst_rej", int'(rej), 0);
    chk("rst_active", int'(adj_active), 0);
    chk("rst_mask", int'(blink_mask), 0);
    rst_n = 1'b1;
    step();

    // Enter adjust mode.
    adj_sw = 1'b1;
    step();
    chk("enter_edit", int'(adj_active), 1);

    // Directed cases.
    do_commit(1, 4, 0, 1'b1);   // accepted, ready already high
    do_commit(1, 7, 0, 1'b0);   // sec_l out of range
    do_commit(3, 10, 0, 1'b0);  // min_l out of range
    do_commit(0, 9, 2, 1'b0);   // upper boundary accepted
    do_commit(1, 5, 0, 1'b0);   // sec_l boundary accepted
    do_commit(1, 6, 0, 1'b0);   // just over sec_l boundary

    // Held request while adj_sw drops and sel/num wander.
    sel = 2'd2; num = 4'd8; btn_set = 1'b1; wr_ready = 1'b0;
    step();
    btn_set = 1'b0;
    chk("hold_rise", int'(wr_valid), 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) adj_sw = 1'b0;
      sel = 2'(i); num = 4'(i + 3);
      step();
      chk("hold_valid", int'(wr_valid), 1);
      chk("hold_sel", int'(wr_sel), 2);
      chk("hold_val", int'(wr_val), 8);
      chk("hold_active", int'(adj_active), 1);
    end
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    $display("held request completed after adj_sw drop");
    chk("drop_valid", int'(wr_valid), 0);
    chk("drop_idle", int'(adj_active), 0);
    step();
    chk("idle_valid", int'(wr_valid), 0);
    last_sel = 2; last_val = 8;

    // Blink cadence on sel=2.
    adj_sw = 1'b1; sel = 2'd2;
    step(); step();
    chk("blink_start", int'(blink_mask), 0);
    for (int k = 1; k <= 8; k++) begin
      tick_adj = 1'b1;
      step();
      tick_adj = 1'b0;
`ifdef STOPWATCH_ADJ_BLINK_EN
      exp_mask = ((k / 2) % 2 == 1) ? 4 : 0;
`else
      exp_mask = 0;
`endif
      $display("tick %0d blink_mask=%b", k, blink_mask);
      chk("blink_tick", int'(blink_mask), exp_mask);
      step();
      chk("blink_steady", int'(blink_mask), exp_mask);
    end
    adj_sw = 1'b0;
    step(); step();
    chk("blink_idle", int'(blink_mask), 0);
    adj_sw = 1'b1;
    step(); step();

    // Button held for 100 cycles: exactly one write.
    sel = 2'd0; num = 4'd3; wr_ready = 1'b1; btn_set = 1'b1;
    valid_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (wr_valid) valid_cycles++;
    end
    btn_set = 1'b0; wr_ready = 1'b0;
    $display("button held 100 cycles: %0d write cycles", valid_cycles);
    chk("held_btn_writes", valid_cycles, 1);
    last_sel = 0; last_val = 3;
    step();

    // Randomized commits against the reference table.
    for (int t = 0; t < 24; t++) begin
      do_commit(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a pending request.
    sel = 2'd3; num = 4'd7; btn_set = 1'b1; wr_ready = 1'b0;
    step();
    btn_set = 1'b0;
    chk("pre_rst_valid", int'(wr_valid), 1);
    step();
    rst_n = 1'b0;
    step();
    $display("reset asserted during pending request");
    chk("mid_rst_valid", int'(wr_valid), 0);
    chk("mid_rst_sel", int'(wr_sel), 0);
    chk("mid_rst_val", int'(wr_val), 0);
    chk("mid_rst_active", int'(adj_active), 0);
    chk("mid_rst_mask", int'(blink_mask), 0);
    rst_n = 1'b1; wr_ready = 1'b1;
    valid_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wr_valid) valid_cycles++;
    end
    chk("no_retry", valid_cycles, 0);
    chk("post_rst_edit", int'(adj_active), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
